// File: rtl/mux_nx1_pipe_pkg.sv
// Shared definitions for the N-to-1 pipelined operand select mux.
// Holds the occupancy-state encoding used by the skid/handshake logic and
// a constant helper used to size the select field from the channel count.
package mux_nx1_pipe_pkg;

  // Occupancy of the two-entry head/skid store.
  //   EMPTY : nothing buffered, outputs idle
  //   ONE   : head register holds the oldest beat
  //   FULL  : head and skid both hold beats, upstream is stalled
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // Ceiling log2 for elaboration-time sizing. A value of 1 gives 0, so
  // callers that need at least one select bit must guard for that.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : mux_nx1_pipe_pkg

// File: rtl/mux_nx1_comb.sv
// Combinational N-to-1 channel select with a range-error flag.
// Channel k lives at in_data[k*WIDTH +: WIDTH]. A select code that does not
// name an existing channel (only possible when NUM_IN is not a power of
// two) produces all-zero data and raises sel_err, so no X or stale channel
// can leak into the captured beat.
module mux_nx1_comb
  import mux_nx1_pipe_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        sel_data,
  output logic                    sel_err
);

  // One bit wider than the select so that NUM_IN itself is representable
  // when NUM_IN is an exact power of two.
  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(NUM_IN);

  // Range check on the raw select code.
  assign sel_err = ({1'b0, sel} >= SEL_LIMIT);

  // Decoded select: an in-range code matches exactly one channel, an
  // out-of-range code matches none and leaves the zero default in place.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule : mux_nx1_comb

// File: rtl/mux_nx1_pipe.sv
// Parametrised N-to-1 operand select mux with a registered output stage.
//
// A beat is selected combinationally from in_data by in_sel and captured
// into a two-entry store (head + skid). The head register drives the
// outputs directly. The skid register absorbs the one beat that can arrive
// in the cycle the downstream stalls, so in_ready depends only on the
// occupancy register and never on out_ready or in_valid in the same cycle.
//
// Handshake: a beat moves on a rising clock edge exactly when valid and
// ready are both high on that side of the block (accept = in_valid &
// in_ready upstream, pop = out_valid & out_ready downstream). A producer
// may not retract or change a beat while valid is high and ready is low;
// likewise out_data/out_sel_err are held constant while out_valid is high
// and out_ready is low. Beats leave in the order they were accepted.
//
// flush empties the store on the next edge regardless of any same-cycle
// accept or pop; a beat accepted in that cycle is discarded.
//
// The occupancy register state_q is the single source of truth for the
// handshake outputs and can be probed hierarchically for debug.
module mux_nx1_pipe
  import mux_nx1_pipe_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Occupancy and the two storage entries.
  occ_state_e       state_q;
  logic [WIDTH-1:0] head_data_q;
  logic             head_err_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             skid_err_q;

  // Selected beat for this cycle, valid only when accept is high.
  logic [WIDTH-1:0] cap_data;
  logic             cap_err;

  logic accept;
  logic pop;

  mux_nx1_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_select (
    .in_data  (in_data),
    .sel      (in_sel),
    .sel_data (cap_data),
    .sel_err  (cap_err)
  );

  // Handshake outputs are pure decodes of the occupancy register.
  assign in_ready    = (state_q != FULL);
  assign out_valid   = (state_q != EMPTY);
  assign out_data    = head_data_q;
  assign out_sel_err = head_err_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Occupancy FSM plus head/skid capture; flush overrides every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else if (flush) begin
      // Contents are left as they are; with state EMPTY they are unused
      // and still hold known values from reset or earlier captures.
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_data_q <= cap_data;
            head_err_q  <= cap_err;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            // Head leaves and the new beat replaces it in the same edge.
            head_data_q <= cap_data;
            head_err_q  <= cap_err;
            state_q     <= ONE;
          end else if (accept) begin
            // Downstream stalled: park the new beat behind the head.
            skid_data_q <= cap_data;
            skid_err_q  <= cap_err;
            state_q     <= FULL;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can change the state.
          if (pop) begin
            head_data_q <= skid_data_q;
            head_err_q  <= skid_err_q;
            state_q     <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

endmodule : mux_nx1_pipe

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
Parametrised N-to-1 operand select mux with a registered output stage and a valid/ready handshake. It generalises the fixed 8-bit 2:1 bit-sliced mux to configurable WIDTH and NUM_IN. A 2-entry skid buffer lets it sit between OoO pipeline stages (issue → operand read/forward) without a combinational ready path. It also flags out-of-range selects and supports a synchronous flush for mispredict recovery.

Parameters:
WIDTH, 8, data width of each input and of out_data
NUM_IN, 4, number of input channels (≥2)
SEL_W, $clog2(NUM_IN), derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; drops all buffered entries
in_data  input  NUM_IN*WIDTH  packed inputs; channel k = in_data[k*WIDTH +: WIDTH]
in_sel  input  SEL_W  binary channel select, sampled with in_valid
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat this cycle
out_data  output  WIDTH  selected data of head entry
out_sel_err  output  1  head entry was captured with in_sel ≥ NUM_IN
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head entry

Behaviour:
- One clock, asynchronous active-low reset.
- Accept = in_valid & in_ready. Capture at clk edge: data = channel in_sel; if in_sel ≥ NUM_IN, data = 0 and err = 1, else err = 0.
- Storage: head register (drives outputs) + skid register; occupancy count 0..2 (states EMPTY, ONE, FULL).
- in_ready = (count != 2); driven purely from registers, with no combinational path from out_ready or in_valid.
- out_valid = (count != 0); out_data and out_sel_err come from the head register.
- Latency: beat accepted at edge t appears on out_valid/out_data after edge t (1 cycle) when EMPTY, or when ONE with pop in the same cycle.
- Transitions, with pop = out_valid & out_ready:
  - EMPTY: accept → ONE (load head).
  - ONE: accept & pop → ONE (load head); accept only → FULL (load skid); pop only → EMPTY.
  - FULL: pop → ONE (skid moves to head); no accept is possible.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Output stability: while out_valid & !out_ready, out_data and out_sel_err hold constant.
- flush: next state is EMPTY regardless of accept/pop in the same cycle. A same-cycle accepted beat is discarded. in_ready = 1 the following cycle.
- Reset (asynchronous, at any time including mid-transfer): count = 0; head/skid data = 0; out_valid = 0; out_data = 0; out_sel_err = 0; in_ready = 1.
- Register contents when count == 0 are don't-care beyond reset, but out_data must not show X.
- NUM_IN not a power of two: out-of-range codes always take the err path.

Decomposition:
- Shared package (e.g. ooo_pipe_pkg): occupancy-state enum {EMPTY, ONE, FULL} and a clog2 helper constant function.
- Natural sub-module: mux_nx1_comb (parametrised WIDTH/NUM_IN combinational select plus range-error flag), instantiated once ahead of the capture logic.
- The skid/handshake logic stays in mux_nx1_pipe.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 → out_valid = 0, out_data = 0x00, in_ready = 1; release → no spurious output.
- Basic select (WIDTH=8, NUM_IN=4): channels = {0x44,0x33,0x22,0x11}, in_sel = 2, out_ready = 1 → one cycle later out_data = 0x33, out_sel_err = 0, out_valid for exactly 1 cycle.
- Backpressure: out_ready = 0, push sel = 0 then sel = 3 → in_ready = 0 after the 2nd accept; out_data holds 0x11. Raise out_ready → 0x11 then 0x44, then in_ready returns to 1.
- Out-of-range (NUM_IN=3): in_sel = 3 → out_data = 0x00, out_sel_err = 1; the next beat with in_sel = 1 gives err = 0.
- Flush: in FULL state, assert flush together with in_valid and out_ready → next cycle out_valid = 0, in_ready = 1; the flushed beats never appear.
- Streaming: 100 random beats with random out_ready (50%) → output sequence equals a reference-model queue, with no loss, duplication or X.
